// File: rtl/dds_pkg.sv
// DDS shared package: waveform mode enum, mode width,
// channel-select width helper and parameter legality check.
package dds_pkg;

  typedef enum logic [1:0] {
    PULSE = 2'd0,
    SAW   = 2'd1,
    TRI   = 2'd2,
    OFF   = 2'd3
  } mode_e;

  localparam int MODE_W = 2;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit params_ok(
    input int num_ch,
    input int bw,
    input int tw,
    input int pw,
    input int pow
  );
    return (num_ch >= 1) && (tw >= 1) && (tw <= pw) &&
           (pow >= 1) && (pow <= pw) && (pow <= bw);
  endfunction

endpackage

// File: rtl/dds_chan.sv
// One DDS channel: phase accumulator, shadow config committed
// on wrap, and a registered waveform stage.
// Ports: clk, rst (sync high), en, sync, wr + wr_* payload in;
// pending, sig (BITWIDTH), wrap (1-cycle pulse) out.
module dds_chan
  import dds_pkg::*;
#(
  parameter int BITWIDTH     = 32,
  parameter int TUNE_WIDTH   = 16,
  parameter int PA_WIDTH     = 23,
  parameter int PA_OUT_WIDTH = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sync,
  input  logic                    wr,
  input  logic [TUNE_WIDTH-1:0]   wr_tune,
  input  logic [PA_OUT_WIDTH-1:0] wr_offset,
  input  logic [PA_OUT_WIDTH-1:0] wr_duty,
  input  logic [MODE_W-1:0]       wr_mode,
  output logic                    pending,
  output logic [BITWIDTH-1:0]     sig,
  output logic                    wrap
);

  localparam int SH = BITWIDTH - PA_OUT_WIDTH;
  localparam int ZX = PA_WIDTH + 1 - TUNE_WIDTH;

  logic [PA_WIDTH-1:0]     acc_q, acc_d;
  logic [TUNE_WIDTH-1:0]   tune_q, tune_d;
  logic [TUNE_WIDTH-1:0]   sh_tune_q, sh_tune_d;
  logic [PA_OUT_WIDTH-1:0] offset_q, offset_d;
  logic [PA_OUT_WIDTH-1:0] sh_offset_q, sh_offset_d;
  logic [PA_OUT_WIDTH-1:0] duty_q, duty_d;
  logic [PA_OUT_WIDTH-1:0] sh_duty_q, sh_duty_d;
  mode_e                   mode_q, mode_d;
  mode_e                   sh_mode_q, sh_mode_d;
  logic                    pend_q, pend_d;
  logic                    wrap_q, wrap_d;
  logic [BITWIDTH-1:0]     sig_q, sig_d;

  logic [PA_WIDTH:0]       sum;
  logic                    commit;
  logic [PA_OUT_WIDTH-1:0] phase;
  logic [PA_OUT_WIDTH-1:0] tri_w;

  always_comb begin
    sum = {1'b0, acc_q} + {{ZX{1'b0}}, tune_q};
    // A stopped or frozen accumulator never wraps, so commit at once.
    commit = pend_q &
             (sync | ~en | (tune_q == '0) | sum[PA_WIDTH]);

    tune_d      = tune_q;
    offset_d    = offset_q;
    duty_d      = duty_q;
    mode_d      = mode_q;
    sh_tune_d   = sh_tune_q;
    sh_offset_d = sh_offset_q;
    sh_duty_d   = sh_duty_q;
    sh_mode_d   = sh_mode_q;
    pend_d      = pend_q;
    acc_d       = acc_q;
    wrap_d      = 1'b0;

    if (commit) begin
      tune_d   = sh_tune_q;
      offset_d = sh_offset_q;
      duty_d   = sh_duty_q;
      mode_d   = sh_mode_q;
      pend_d   = 1'b0;
    end

    // wr only arrives while not pending, so never races commit.
    if (wr) begin
      sh_tune_d   = wr_tune;
      sh_offset_d = wr_offset;
      sh_duty_d   = wr_duty;
      sh_mode_d   = mode_e'(wr_mode);
      pend_d      = 1'b1;
    end

    if (sync) begin
      acc_d = '0;
    end else if (en) begin
      acc_d  = sum[PA_WIDTH-1:0];
      wrap_d = sum[PA_WIDTH];
    end

    phase = acc_q[PA_WIDTH-1 -: PA_OUT_WIDTH] + offset_q;
    tri_w = (phase[PA_OUT_WIDTH-1] ? ~phase : phase) << 1;

    sig_d = '0;
    unique case (mode_q)
      PULSE:   sig_d = (phase < duty_q) ? '1 : '0;
      SAW:     sig_d = BITWIDTH'(phase) << SH;
      TRI:     sig_d = BITWIDTH'(tri_w) << SH;
      default: sig_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      tune_q      <= '0;
      offset_q    <= '0;
      duty_q      <= '0;
      mode_q      <= OFF;
      sh_tune_q   <= '0;
      sh_offset_q <= '0;
      sh_duty_q   <= '0;
      sh_mode_q   <= OFF;
      pend_q      <= 1'b0;
      wrap_q      <= 1'b0;
      sig_q       <= '0;
    end else begin
      acc_q       <= acc_d;
      tune_q      <= tune_d;
      offset_q    <= offset_d;
      duty_q      <= duty_d;
      mode_q      <= mode_d;
      sh_tune_q   <= sh_tune_d;
      sh_offset_q <= sh_offset_d;
      sh_duty_q   <= sh_duty_d;
      sh_mode_q   <= sh_mode_d;
      pend_q      <= pend_d;
      wrap_q      <= wrap_d;
      sig_q       <= sig_d;
    end
  end

  assign pending = pend_q;
  assign sig     = sig_q;
  assign wrap    = wrap_q;

endmodule

// File: rtl/dds_mc.sv
// Multi-channel DDS top: config write decode, cfg_ready mux
// and output packing around NUM_CH dds_chan instances.
// Ports: clk, RST, cfg_* write port, EN, SYNC in;
// cfg_ready, sig_out (NUM_CH*BITWIDTH), wrap (NUM_CH) out.
module dds_mc
  import dds_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int BITWIDTH     = 32,
  parameter int TUNE_WIDTH   = 16,
  parameter int PA_WIDTH     = 23,
  parameter int PA_OUT_WIDTH = 14
) (
  input  logic                             clk,
  input  logic                             RST,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [ch_width(NUM_CH)-1:0]      cfg_ch,
  input  logic [TUNE_WIDTH-1:0]            cfg_tune,
  input  logic [PA_OUT_WIDTH-1:0]          cfg_offset,
  input  logic [PA_OUT_WIDTH-1:0]          cfg_duty,
  input  logic [MODE_W-1:0]                cfg_mode,
  input  logic                             EN,
  input  logic                             SYNC,
  output logic [NUM_CH*BITWIDTH-1:0]       sig_out,
  output logic [NUM_CH-1:0]                wrap
);

  localparam int CH_W = ch_width(NUM_CH);

  if (!params_ok(NUM_CH, BITWIDTH, TUNE_WIDTH,
                 PA_WIDTH, PA_OUT_WIDTH)) begin : g_bad_params
    $error("dds_mc: illegal parameter combination");
  end

  logic [NUM_CH-1:0] pend;
  logic              ch_ok;
  logic              accept;

  always_comb begin
    ch_ok     = {1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH);
    cfg_ready = 1'b0;
    // Unmapped channels always accept and silently drop.
    if (!RST) cfg_ready = ch_ok ? ~pend[cfg_ch] : 1'b1;
    accept = cfg_valid & cfg_ready & ch_ok;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic wr_k;
    assign wr_k = accept & (cfg_ch == CH_W'(k));

    dds_chan #(
      .BITWIDTH    (BITWIDTH),
      .TUNE_WIDTH  (TUNE_WIDTH),
      .PA_WIDTH    (PA_WIDTH),
      .PA_OUT_WIDTH(PA_OUT_WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst      (RST),
      .en       (EN),
      .sync     (SYNC),
      .wr       (wr_k),
      .wr_tune  (cfg_tune),
      .wr_offset(cfg_offset),
      .wr_duty  (cfg_duty),
      .wr_mode  (cfg_mode),
      .pending  (pend[k]),
      .sig      (sig_out[k*BITWIDTH +: BITWIDTH]),
      .wrap     (wrap[k])
    );
  end

endmodule

// File: tb/tb_dds_mc.sv
// Directed self-checking bench for dds_mc
// (default parameters: 4 ch, 32-bit out, 23-bit acc).
module tb_dds_mc;

  logic         clk = 1'b0;
  logic         RST = 1'b1;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [1:0]   cfg_ch = '0;
  logic [15:0]  cfg_tune = '0;
  logic [13:0]  cfg_offset = '0;
  logic [13:0]  cfg_duty = '0;
  logic [1:0]   cfg_mode = '0;
  logic         EN = 1'b0;
  logic         SYNC = 1'b0;
  logic [127:0] sig_out;
  logic [3:0]   wrap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dds_mc dut (
    .clk       (clk),
    .RST       (RST),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_tune  (cfg_tune),
    .cfg_offset(cfg_offset),
    .cfg_duty  (cfg_duty),
    .cfg_mode  (cfg_mode),
    .EN        (EN),
    .SYNC      (SYNC),
    .sig_out   (sig_out),
    .wrap      (wrap)
  );

  // Saw code for a 14-bit phase, left-justified in 32 bits.
  function automatic logic [31:0] saw_exp(input int ph);
    return 32'(ph & 16383) << 18;
  endfunction

  // Triangle: rises 0..16382 over the first half, falls after.
  function automatic logic [31:0] tri_exp(input int ph);
    int p;
    int t;
    p = ph & 16383;
    t = (p < 8192) ? 2 * p : 2 * (16383 - p);
    return 32'(t & 16383) << 18;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int ch, input int tune,
                         input int off, input int duty,
                         input int mode);
    cfg_ch     = 2'(ch);
    cfg_tune   = 16'(tune);
    cfg_offset = 14'(off);
    cfg_duty   = 14'(duty);
    cfg_mode   = 2'(mode);
    cfg_valid  = 1'b1;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    cfg_valid = 1'b0;
    EN = 1'b0;
    SYNC = 1'b0;
    tick;
    tick;
    RST = 1'b0;
  endtask

  // Start ch0 saw at tune 0x8000; returns at sample point i=0.
  task automatic start_ch0_saw;
    EN = 1'b1;
    set_cfg(0, 16'h8000, 0, 0, 1);
    tick;
    cfg_valid = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    set_cfg(0, 16'h8000, 0, 0, 1);
    EN = 1'b1;
    SYNC = 1'b1;
    tick;
    tick;
    checks++;
    if (sig_out !== '0) begin
      errors++;
      $display("FAIL rst_sig got %h exp 0", sig_out);
    end
    checks++;
    if (wrap !== 4'h0) begin
      errors++;
      $display("FAIL rst_wrap got %h exp 0", wrap);
    end
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready_in_rst got %b exp 0", cfg_ready);
    end
    RST = 1'b0;
    cfg_valid = 1'b0;
    EN = 1'b0;
    SYNC = 1'b0;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready_after got %b exp 1", cfg_ready);
    end
  endtask

  task automatic test_saw;
    do_reset;
    EN = 1'b1;
    set_cfg(0, 16'h8000, 0, 0, 1);
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL saw_ready_idle got %b exp 1", cfg_ready);
    end
    tick;
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL saw_ready_pend got %b exp 0", cfg_ready);
    end
    tick;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL saw_tune0_commit got %b exp 1", cfg_ready);
    end
    tick;
    for (int i = 0; i <= 520; i++) begin
      if (i > 0) tick;
      checks++;
      if (sig_out[31:0] !== saw_exp(i * 64)) begin
        errors++;
        $display("FAIL saw_code i=%0d got %h exp %h",
                 i, sig_out[31:0], saw_exp(i * 64));
      end
      checks++;
      if (wrap[0] !== ((i % 256) == 255)) begin
        errors++;
        $display("FAIL saw_wrap i=%0d got %b", i, wrap[0]);
      end
      checks++;
      if (sig_out[127:32] !== '0 || wrap[3:1] !== 3'b0) begin
        errors++;
        $display("FAIL saw_others i=%0d got %h/%b exp 0",
                 i, sig_out[127:32], wrap[3:1]);
      end
    end
  endtask

  task automatic test_pulse;
    logic [31:0] exp_v;
    do_reset;
    EN = 1'b1;
    set_cfg(1, 16'h8000, 0, 14'h2000, 0);
    tick;
    cfg_valid = 1'b0;
    tick;
    tick;
    for (int i = 0; i < 300; i++) begin
      if (i > 0) tick;
      exp_v = ((i % 256) < 128) ? 32'hFFFF_FFFF : 32'h0;
      checks++;
      if (sig_out[63:32] !== exp_v) begin
        errors++;
        $display("FAIL pulse i=%0d got %h exp %h",
                 i, sig_out[63:32], exp_v);
      end
    end
    do_reset;
    EN = 1'b1;
    set_cfg(1, 16'h8000, 0, 0, 0);
    tick;
    cfg_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick;
      checks++;
      if (sig_out[63:32] !== 32'h0) begin
        errors++;
        $display("FAIL pulse_duty0 i=%0d got %h exp 0",
                 i, sig_out[63:32]);
      end
    end
  endtask

  task automatic test_retune;
    int  i;
    bit  found;
    do_reset;
    start_ch0_saw;
    for (i = 0; i < 100; ) begin
      tick;
      i++;
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL retune_ready_pre got %b exp 1", cfg_ready);
    end
    set_cfg(0, 16'h4000, 0, 0, 1);
    tick;
    i = 101;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL retune_ready_pend got %b exp 0", cfg_ready);
    end
    // Second write attempt stays presented while pending.
    cfg_tune = 16'h2000;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      tick;
      i++;
      if (wrap[0]) begin
        found = 1'b1;
        cfg_valid = 1'b0;
        checks++;
        if (i != 255) begin
          errors++;
          $display("FAIL retune_wrap_at got %0d exp 255", i);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
          errors++;
          $display("FAIL retune_ready_wrap got %b exp 1", cfg_ready);
        end
      end else begin
        checks++;
        if (cfg_ready !== 1'b0) begin
          errors++;
          $display("FAIL retune_stall i=%0d got %b exp 0",
                   i, cfg_ready);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL retune_wrap_timeout got none exp wrap");
      cfg_valid = 1'b0;
      i = 255;
    end
    while (i < 770) begin
      tick;
      i++;
      checks++;
      if (sig_out[31:0] !== saw_exp((i - 256) * 32)) begin
        errors++;
        $display("FAIL retune_code i=%0d got %h exp %h",
                 i, sig_out[31:0], saw_exp((i - 256) * 32));
      end
      checks++;
      if (wrap[0] !== (i == 767)) begin
        errors++;
        $display("FAIL retune_period i=%0d got %b", i, wrap[0]);
      end
    end
  endtask

  task automatic test_sync;
    do_reset;
    EN = 1'b1;
    set_cfg(0, 16'h8000, 0, 0, 1);
    tick;
    set_cfg(2, 16'h8000, 14'h2000, 0, 2);
    tick;
    cfg_valid = 1'b0;
    repeat (5) tick;
    SYNC = 1'b1;
    tick;
    SYNC = 1'b0;
    checks++;
    if (wrap !== 4'h0) begin
      errors++;
      $display("FAIL sync_nowrap got %h exp 0", wrap);
    end
    for (int i = 0; i < 300; i++) begin
      tick;
      checks++;
      if (sig_out[31:0] !== saw_exp(i * 64)) begin
        errors++;
        $display("FAIL sync_ch0 i=%0d got %h exp %h",
                 i, sig_out[31:0], saw_exp(i * 64));
      end
      checks++;
      if (sig_out[95:64] !== tri_exp(i * 64 + 8192)) begin
        errors++;
        $display("FAIL sync_ch2_tri i=%0d got %h exp %h",
                 i, sig_out[95:64], tri_exp(i * 64 + 8192));
      end
      checks++;
      if (wrap[0] !== (i == 255) || wrap[2] !== (i == 255)) begin
        errors++;
        $display("FAIL sync_wrap_align i=%0d got %b/%b",
                 i, wrap[0], wrap[2]);
      end
    end
  endtask

  task automatic test_en_hold_and_rst;
    do_reset;
    start_ch0_saw;
    repeat (50) tick;
    checks++;
    if (sig_out[31:0] !== saw_exp(50 * 64)) begin
      errors++;
      $display("FAIL hold_pre got %h exp %h",
               sig_out[31:0], saw_exp(50 * 64));
    end
    EN = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick;
      checks++;
      if (sig_out[31:0] !== saw_exp(51 * 64) || wrap !== 4'h0) begin
        errors++;
        $display("FAIL hold k=%0d got %h/%h exp %h/0",
                 k, sig_out[31:0], wrap, saw_exp(51 * 64));
      end
      if (k == 2) set_cfg(0, 16'h4000, 0, 0, 1);
      if (k == 3) begin
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
          errors++;
          $display("FAIL hold_pend got %b exp 0", cfg_ready);
        end
      end
      if (k == 4) begin
        checks++;
        if (cfg_ready !== 1'b1) begin
          errors++;
          $display("FAIL hold_commit got %b exp 1", cfg_ready);
        end
      end
    end
    EN = 1'b1;
    tick;
    checks++;
    if (sig_out[31:0] !== saw_exp(51 * 64)) begin
      errors++;
      $display("FAIL resume0 got %h exp %h",
               sig_out[31:0], saw_exp(51 * 64));
    end
    tick;
    checks++;
    if (sig_out[31:0] !== saw_exp(51 * 64 + 32)) begin
      errors++;
      $display("FAIL resume1 got %h exp %h",
               sig_out[31:0], saw_exp(51 * 64 + 32));
    end
    set_cfg(0, 16'h2000, 0, 0, 1);
    tick;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pend got %b exp 0", cfg_ready);
    end
    RST = 1'b1;
    set_cfg(0, 16'h8000, 14'h1000, 0, 1);
    #1;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready got %b exp 0", cfg_ready);
    end
    tick;
    RST = 1'b0;
    cfg_valid = 1'b0;
    #1;
    checks++;
    if (sig_out !== '0 || wrap !== 4'h0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_release got %h/%h/%b exp 0/0/1",
               sig_out, wrap, cfg_ready);
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (sig_out !== '0) begin
        errors++;
        $display("FAIL midrst_dropped i=%0d got %h exp 0",
                 i, sig_out);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_saw;
    test_pulse;
    test_retune;
    test_sync;
    test_en_hold_and_rst;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_mc.md
DDS_MC -- requirements
Module: dds_mc

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of independent DDS channels, minimum 1.
REQ-002 The block SHALL have parameter BITWIDTH, default 32: amplitude width per channel.
REQ-003 The block SHALL have parameter TUNE_WIDTH, default 16: tuning word width, at most PA_WIDTH.
REQ-004 The block SHALL have parameter PA_WIDTH, default 23: phase accumulator width.
REQ-005 The block SHALL have parameter PA_OUT_WIDTH, default 14: truncated phase width, at most PA_WIDTH and at most BITWIDTH.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port cfg_valid, input, 1 bit: config write request.
REQ-009 The block SHALL have port cfg_ready, output, 1 bit: config write can be accepted.
REQ-010 The block SHALL have port cfg_ch, input, $clog2(NUM_CH) bits (min 1): target channel.
REQ-011 The block SHALL have ports cfg_tune [TUNE_WIDTH], cfg_offset [PA_OUT_WIDTH], cfg_duty [PA_OUT_WIDTH] and cfg_mode [2], all inputs, carrying the config payload.
REQ-012 The block SHALL have port EN, input, 1 bit: global accumulate enable.
REQ-013 The block SHALL have port SYNC, input, 1 bit: zero all accumulators for phase alignment.
REQ-014 The block SHALL have port sig_out, output, NUM_CH*BITWIDTH bits: channel k occupies bits [k*BITWIDTH +: BITWIDTH].
REQ-015 The block SHALL have port wrap, output, NUM_CH bits: one-cycle pulse per channel on accumulator overflow.

Function
REQ-016 Each channel SHALL hold an active config (tune, offset, duty, mode) and a shadow copy with a pending flag.
REQ-017 A write SHALL be accepted on a rising edge where cfg_valid and cfg_ready are both high; it loads the shadow of cfg_ch and sets that channel's pending flag.
REQ-018 cfg_ready SHALL equal the inverse of the pending flag of the channel addressed by cfg_ch, and SHALL be 0 while RST is high.
REQ-019 A cfg_ch value of NUM_CH or above SHALL give cfg_ready=1 and the write SHALL be discarded with no state change.
REQ-020 A pending shadow SHALL commit to the active config, clearing pending, on the edge where that channel's accumulator wraps. This keeps frequency changes phase-continuous and glitch-free.
REQ-021 A pending shadow SHALL commit on the next edge if EN=0, the active tune is 0, or SYNC=1. A write accepted in such a cycle SHALL commit on the following edge.
REQ-022 When EN=1, each accumulator SHALL update as acc <= (acc + zero-extended tune) mod 2^PA_WIDTH. When EN=0, accumulators SHALL hold.
REQ-023 wrap[k] SHALL be 1 for exactly the cycle following an addition that produced a carry out of PA_WIDTH bits.
REQ-024 SYNC=1 SHALL clear all accumulators to 0 on that edge with no wrap pulse, and SHALL take priority over EN.
REQ-025 Phase SHALL be computed as (acc[PA_WIDTH-1 -: PA_OUT_WIDTH] + offset) mod 2^PA_OUT_WIDTH.
REQ-026 mode 0 (pulse) SHALL output all ones if phase < duty, else 0. duty=0 gives constant 0.
REQ-027 mode 1 (saw) SHALL output phase left-justified in BITWIDTH bits, with the lower bits 0.
REQ-028 mode 2 (triangle) SHALL output t left-justified, where t = phase<<1 if phase MSB=0, else (~phase)<<1, taken as PA_OUT_WIDTH bits.
REQ-029 mode 3 (off) SHALL output 0.
REQ-030 sig_out SHALL be registered with 1-cycle latency from the accumulator register: sig_out at edge n+1 reflects the acc and active config held after edge n.

Reset
REQ-031 While RST is high on an edge, the block SHALL clear acc, tune, offset, duty and pending to 0, set mode to 3, and drive sig_out=0 and wrap=0. RST SHALL override SYNC, EN and cfg_valid.
REQ-032 RST asserted mid-operation SHALL discard pending shadows, and a write presented in that cycle SHALL be dropped.

Structure
REQ-033 Package dds_pkg SHALL hold the mode enum (PULSE, SAW, TRI, OFF), the mode width constant, and any parameter legality checks, shared with the existing dds.
REQ-034 Sub-module dds_chan (accumulator, shadow/commit logic, waveform stage) SHALL be instantiated NUM_CH times by a generate loop. The top SHALL hold only write decode, cfg_ready mux and output packing.

Verification (defaults; tune 0x8000 gives phase step 64 and a 256-cycle period)
REQ-035 Reset then write ch0 tune=0x8000, mode=1, EN=1 SHALL give ch0 saw codes 0, 64<<18, 128<<18, ...; wrap[0] SHALL pulse every 256 cycles; other channels SHALL stay 0.
REQ-036 Writing ch1 with mode=0, duty=0x2000 and tune=0x8000 SHALL produce all ones for 128 cycles and 0 for 128 cycles; duty=0 SHALL give constant 0.
REQ-037 Writing new tune 0x4000 to running ch0 mid-period SHALL hold cfg_ready low until wrap[0]. The period after the wrap SHALL be 512 cycles, and a second write attempt while pending SHALL stall.
REQ-038 Setting ch2 offset=0x2000 in mode 2 with the same tune as ch0, then SYNC for 1 cycle, SHALL leave ch2 leading ch0 by 1/2 period, with all wraps aligned.
REQ-039 Asserting EN=0 for 10 cycles SHALL hold outputs constant and commit a pending write on the next edge. Asserting RST mid-run SHALL give sig_out=0, wrap=0 and cfg_ready=1 on the first cycle after release.
